cbg_benes_net: RTL and testbench

CBG_BENES_NET -- requirements
Module: cbg_benes_net

---
 rtl/cbg_benes_pkg.sv | 38 +++
 rtl/benes_layer.sv | 28 ++
 rtl/cbg_benes_net.sv | 110 +++++++++++
 tb/tb_cbg_benes_net.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbg_benes_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cbg_benes_pkg
// Brief   : Shared geometry helpers for the in-place Benes permutation network.
// Revision: 1.0
// ============================================================================
package cbg_benes_pkg;

  function automatic int tag_width(input int size);
    return $clog2(size);
  endfunction

  function automatic int stage_count(input int size);
    return 2 * $clog2(size) - 1;
  endfunction

  function automatic int bit_width(input int size);
    return stage_count(size) * size / 2;
  endfunction

  // Gaps double towards the middle layer, then mirror back down.
  function automatic int layer_gap(input int size, input int k);
    int s;
    int m;
    s = stage_count(size);
    m = (k < s - 1 - k) ? k : s - 1 - k;
    return 1 << m;
  endfunction

  // Start of stage k's leftover ctrl slices in the triangular ctrl store.
  function automatic int ctrl_offset(input int size, input int k);
    int s;
    s = stage_count(size);
    return (size / 2) * (k * (s - 1) - (k * (k - 1)) / 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/benes_layer.sv
`default_nettype none
// ============================================================================
// Module  : benes_layer
// Brief   : One combinational column of 2x2 switches pairing lanes GAP apart.
// Revision: 1.0
// ============================================================================
module benes_layer #(
  parameter int SIZE   = 32,
  parameter int DWIDTH = 8,
  parameter int GAP    = 1
) (
  input  logic [SIZE*DWIDTH-1:0] in_data,
  input  logic [SIZE/2-1:0]      ctrl,
  output logic [SIZE*DWIDTH-1:0] out_data
);

  for (genvar j = 0; j < SIZE / 2; j++) begin : g_switch
    localparam int c_lo = (j % GAP) + 2 * GAP * (j / GAP);
    localparam int c_hi = c_lo + GAP;

    assign out_data[c_lo*DWIDTH +: DWIDTH] = ctrl[j] ? in_data[c_hi*DWIDTH +: DWIDTH]
                                                     : in_data[c_lo*DWIDTH +: DWIDTH];
    assign out_data[c_hi*DWIDTH +: DWIDTH] = ctrl[j] ? in_data[c_lo*DWIDTH +: DWIDTH]
                                                     : in_data[c_hi*DWIDTH +: DWIDTH];
  end

endmodule
`default_nettype wire

// File: rtl/cbg_benes_net.sv
`default_nettype none
// ============================================================================
// Module  : cbg_benes_net
// Brief   : Fully pipelined Benes lane permuter with valid/ready flow control.
// Revision: 1.0
// ============================================================================
module cbg_benes_net
  import cbg_benes_pkg::*;
#(
  parameter  int SIZE     = 32,
  parameter  int DWIDTH   = 8,
  localparam int TAGWIDTH = tag_width(SIZE),
  localparam int STAGES   = 2 * TAGWIDTH - 1,
  localparam int BITWIDTH = STAGES * SIZE / 2,
  localparam int OCCWIDTH = $clog2(STAGES + 1)
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SIZE*DWIDTH-1:0]   in_data,
  input  logic [BITWIDTH-1:0]      in_ctrl,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SIZE*DWIDTH-1:0]   out_data,
  output logic [OCCWIDTH-1:0]      occupancy
);

  localparam int c_half      = SIZE / 2;
  localparam int c_ctrl_bits = ctrl_offset(SIZE, STAGES - 1);

  logic [SIZE*DWIDTH-1:0] r_data      [STAGES];
  logic [SIZE*DWIDTH-1:0] w_layer_in  [STAGES];
  logic [SIZE*DWIDTH-1:0] w_layer_out [STAGES];
  logic [c_half-1:0]      w_layer_ctrl[STAGES];
  logic [STAGES-1:0]      r_valid;
  logic [STAGES-1:0]      w_ready;
  logic [c_ctrl_bits-1:0] r_ctrl;
  logic [OCCWIDTH-1:0]    r_occupancy;
  logic                   w_accept;
  logic                   w_emit;

  for (genvar k = 0; k < STAGES; k++) begin : g_layer
    if (k == 0) begin : g_first
      assign w_layer_in[k]   = in_data;
      assign w_layer_ctrl[k] = in_ctrl[c_half-1:0];
    end else begin : g_rest
      assign w_layer_in[k]   = r_data[k-1];
      assign w_layer_ctrl[k] = r_ctrl[ctrl_offset(SIZE, k - 1) +: c_half];
    end

    benes_layer #(
      .SIZE   (SIZE),
      .DWIDTH (DWIDTH),
      .GAP    (layer_gap(SIZE, k))
    ) u_layer (
      .in_data  (w_layer_in[k]),
      .ctrl     (w_layer_ctrl[k]),
      .out_data (w_layer_out[k])
    );
  end

  // Unrolled ready chain: a stage can advance if any stage at or after it has a hole.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_ready[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!r_valid[j]) w_ready[k] = 1'b1;
      end
    end
  end

  assign in_ready  = w_ready[0];
  assign out_valid = r_valid[STAGES-1];
  assign out_data  = r_data[STAGES-1];
  assign occupancy = r_occupancy;
  assign w_accept  = in_valid && w_ready[0];
  assign w_emit    = r_valid[STAGES-1] && out_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_valid     <= '0;
      r_ctrl      <= '0;
      r_occupancy <= '0;
      for (int k = 0; k < STAGES; k++) r_data[k] <= '0;
    end else begin
      if (w_ready[0]) begin
        r_valid[0] <= in_valid;
        if (in_valid) begin
          r_data[0] <= w_layer_out[0];
          for (int j = 0; j < (STAGES - 1) * c_half; j++) r_ctrl[j] <= in_ctrl[c_half + j];
        end
      end
      // Each stage keeps only the slices still ahead of it, dropping the one just used.
      for (int k = 1; k < STAGES; k++) begin
        if (w_ready[k]) begin
          r_valid[k] <= r_valid[k-1];
          if (r_valid[k-1]) begin
            r_data[k] <= w_layer_out[k];
            for (int j = 0; j < (STAGES - 1 - k) * c_half; j++)
              r_ctrl[ctrl_offset(SIZE, k) + j] <= r_ctrl[ctrl_offset(SIZE, k - 1) + c_half + j];
          end
        end
      end
      r_occupancy <= r_occupancy + OCCWIDTH'(w_accept) - OCCWIDTH'(w_emit);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cbg_benes_net.sv
`default_nettype none
// ============================================================================
// Module  : tb_cbg_benes_net
// Brief   : Randomised self-checking bench for cbg_benes_net with routing model.
// Revision: 1.0
// ============================================================================
module tb_cbg_benes_net;

  localparam int SIZE = 32;
  localparam int DW   = 8;
  localparam int TW   = 5;
  localparam int ST   = 9;
  localparam int HALF = SIZE / 2;
  localparam int BW   = ST * HALF;
  localparam int SW   = SIZE * DW;
  localparam int OCCW = 4;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_data;
  logic [BW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_data;
  logic [OCCW-1:0] occupancy;

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int occ_model = 0;
  logic last_stall;
  logic last_acc;
  logic [SW-1:0] last_out;
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] got_q[$];
  int acc_cyc[$];
  int emit_cyc[$];

  always #5 clk = ~clk;

  cbg_benes_net #(.SIZE(SIZE), .DWIDTH(DW)) u_dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  // Switch number within a layer for the pair whose lower lane is q (bit b clear).
  function automatic int sw_index(input int q, input int b);
    return (q & ((1 << b) - 1)) | ((q >> (b + 1)) << b);
  endfunction

  // Looping-algorithm router: ctrl such that out[x] = in[p[x]].
  function automatic logic [BW-1:0] route_perm(input int p[SIZE]);
    logic [BW-1:0] c;
    int t[SIZE];
    int nt[SIZE];
    int who[SIZE];
    int s[SIZE];
    bit asg[SIZE];
    int g;
    int cur;
    int pr;
    c = '0;
    for (int x = 0; x < SIZE; x++) t[p[x]] = x;
    for (int b = 0; b < TW; b++) begin
      g = 1 << b;
      for (int q = 0; q < SIZE; q++) begin
        who[t[q]] = q;
        asg[q] = 1'b0;
        s[q] = 0;
      end
      if (b == TW - 1) begin
        for (int q = 0; q < SIZE; q++)
          if ((q & g) == 0) c[b*HALF + sw_index(q, b)] = t[q][b];
      end else begin
        for (int q = 0; q < SIZE; q++) begin
          cur = q;
          while (!asg[cur]) begin
            asg[cur] = 1'b1;
            s[cur] = 0;
            pr = cur ^ g;
            asg[pr] = 1'b1;
            s[pr] = 1;
            cur = who[t[pr] ^ g];
          end
        end
        for (int q = 0; q < SIZE; q++) begin
          if ((q & g) == 0) c[b*HALF + sw_index(q, b)] = (s[q] == 1);
          if (s[q] == 0) c[(ST-1-b)*HALF + sw_index(t[q] & ~g, b)] = t[q][b];
        end
        for (int q = 0; q < SIZE; q++) nt[(q & ~g) | (s[q] << b)] = (t[q] & ~g) | (s[q] << b);
        t = nt;
      end
    end
    return c;
  endfunction

  function automatic logic [SW-1:0] apply_perm(input logic [SW-1:0] d, input int p[SIZE]);
    logic [SW-1:0] e;
    for (int x = 0; x < SIZE; x++) e[x*DW +: DW] = d[p[x]*DW +: DW];
    return e;
  endfunction

  function automatic logic [SW-1:0] rand_data();
    logic [SW-1:0] d;
    for (int x = 0; x < SIZE; x++) d[x*DW +: DW] = DW'($urandom);
    return d;
  endfunction

  task automatic rand_perm(output int p[SIZE]);
    int j;
    int tmp;
    for (int x = 0; x < SIZE; x++) p[x] = x;
    for (int x = SIZE - 1; x > 0; x--) begin
      j = $urandom_range(x, 0);
      tmp = p[x];
      p[x] = p[j];
      p[j] = tmp;
    end
  endtask

  // Drives one cycle from posedge+1 and records handshakes seen at the negedge.
  task automatic cycle(input logic v, input logic [SW-1:0] d, input logic [BW-1:0] c,
                       input logic [SW-1:0] e, input logic r);
    in_valid = v;
    in_data = d;
    in_ctrl = c;
    out_ready = r;
    @(negedge clk);
    ncyc++;
    last_stall = out_valid && !out_ready;
    last_out = out_data;
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      exp_q.push_back(e);
      acc_cyc.push_back(ncyc);
      occ_model++;
    end
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      emit_cyc.push_back(ncyc);
      occ_model--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, 1'b1);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    acc_cyc.delete();
    emit_cyc.delete();
  endtask

  task automatic test_reset();
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    if (occupancy !== '0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
  endtask

  task automatic test_identity();
    logic [SW-1:0] d;
    clear_sb();
    for (int x = 0; x < SIZE; x++) d[x*DW +: DW] = DW'(x);
    cycle(1'b1, d, '0, d, 1'b1);
    idle(12);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL identity_count got %0d want 1", got_q.size());
    end else begin
      checks += 2;
      if (got_q[0] !== d) begin errors++; $display("FAIL identity_data got %h want %h", got_q[0], d); end
      if (emit_cyc[0] - acc_cyc[0] != ST) begin
        errors++; $display("FAIL identity_latency got %0d want %0d", emit_cyc[0] - acc_cyc[0], ST);
      end
    end
    checks++;
    if (occupancy !== '0) begin errors++; $display("FAIL identity_occupancy got %0d want 0", occupancy); end
  endtask

  task automatic test_single_swap();
    logic [SW-1:0] d;
    int p[SIZE];
    clear_sb();
    for (int x = 0; x < SIZE; x++) p[x] = x;
    p[0] = 1;
    p[1] = 0;
    d = rand_data();
    cycle(1'b1, d, BW'(1), apply_perm(d, p), 1'b1);
    idle(12);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL swap_count got %0d want 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL swap_data got %h want %h", got_q[0], exp_q[0]); end
    end
  endtask

  task automatic test_reversal();
    logic [SW-1:0] d;
    int p[SIZE];
    clear_sb();
    for (int x = 0; x < SIZE; x++) p[x] = SIZE - 1 - x;
    d = rand_data();
    cycle(1'b1, d, route_perm(p), apply_perm(d, p), 1'b1);
    idle(12);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL reverse_count got %0d want 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL reverse_data got %h want %h", got_q[0], exp_q[0]); end
    end
  endtask

  task automatic test_random_perms();
    logic [SW-1:0] d;
    int p[SIZE];
    clear_sb();
    for (int i = 0; i < 100; i++) begin
      rand_perm(p);
      d = rand_data();
      cycle(1'b1, d, route_perm(p), apply_perm(d, p), 1'b1);
    end
    idle(14);
    checks++;
    if (got_q.size() != 100) begin
      errors++; $display("FAIL perms_count got %0d want 100", got_q.size());
    end else begin
      for (int i = 0; i < 100; i++) begin
        checks += 2;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL perms_data[%0d] got %h want %h", i, got_q[i], exp_q[i]);
        end
        if (emit_cyc[i] - acc_cyc[i] != ST) begin
          errors++; $display("FAIL perms_latency[%0d] got %0d want %0d", i, emit_cyc[i] - acc_cyc[i], ST);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [SW-1:0] d;
    int p[SIZE];
    clear_sb();
    occ_model = 0;
    for (int i = 0; i < 20; i++) begin
      rand_perm(p);
      d = rand_data();
      cycle(1'b1, d, route_perm(p), apply_perm(d, p), 1'b0);
    end
    checks += 3;
    if (exp_q.size() != ST) begin errors++; $display("FAIL bp_accepted got %0d want %0d", exp_q.size(), ST); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    if (occupancy !== OCCW'(ST)) begin errors++; $display("FAIL bp_occupancy got %0d want %0d", occupancy, ST); end
    for (int i = 0; i < 40 && got_q.size() < exp_q.size(); i++) cycle(1'b0, '0, '0, '0, 1'b1);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_drain got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_order[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_random_flow();
    logic [SW-1:0] d;
    logic [SW-1:0] e;
    logic [BW-1:0] c;
    logic v;
    int p[SIZE];
    clear_sb();
    rand_perm(p);
    d = rand_data();
    c = route_perm(p);
    e = apply_perm(d, p);
    for (int n = 0; n < 20000 && exp_q.size() < 1000; n++) begin
      v = ($urandom_range(3, 0) != 0);
      cycle(v, d, c, e, ($urandom_range(2, 0) != 0));
      if (last_acc) begin
        rand_perm(p);
        d = rand_data();
        c = route_perm(p);
        e = apply_perm(d, p);
      end
      checks++;
      if (occupancy !== OCCW'(occ_model)) begin
        errors++; $display("FAIL flow_occupancy got %0d want %0d", occupancy, occ_model);
      end
      if (last_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== last_out) begin
          errors++; $display("FAIL flow_stall_hold got %b/%h want 1/%h", out_valid, out_data, last_out);
        end
      end
    end
    for (int i = 0; i < 40 && got_q.size() < exp_q.size(); i++) cycle(1'b0, '0, '0, '0, 1'b1);
    checks += 2;
    if (exp_q.size() != 1000) begin errors++; $display("FAIL flow_accepted got %0d want 1000", exp_q.size()); end
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL flow_count got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL flow_order[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [SW-1:0] d;
    int p[SIZE];
    clear_sb();
    for (int i = 0; i < 5; i++) begin
      d = rand_data();
      rand_perm(p);
      cycle(1'b1, d, route_perm(p), apply_perm(d, p), 1'b1);
    end
    in_valid = 1'b0;
    n_rst = 1'b0;
    #2;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    if (occupancy !== '0) begin errors++; $display("FAIL midrst_occupancy got %0d want 0", occupancy); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    clear_sb();
    occ_model = 0;
    rand_perm(p);
    d = rand_data();
    cycle(1'b1, d, route_perm(p), apply_perm(d, p), 1'b1);
    idle(15);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL midrst_count got %0d want 1", got_q.size());
    end else begin
      checks += 2;
      if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL midrst_data got %h want %h", got_q[0], exp_q[0]); end
      if (emit_cyc[0] - acc_cyc[0] != ST) begin
        errors++; $display("FAIL midrst_latency got %0d want %0d", emit_cyc[0] - acc_cyc[0], ST);
      end
    end
  endtask

  initial begin
    n_rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_ctrl = '0;
    out_ready = 1'b0;
    #3;
    test_reset();
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    test_identity();
    test_single_swap();
    test_reversal();
    test_random_perms();
    test_backpressure();
    test_random_flow();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
